// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: load-use bubbles,
// taken-branch flushes, memory-busy freezes and saturating event counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic             EXE_memRead,
  input  logic [4:0]       EXE_rd_addr,
  input  logic             EXE_branch_taken,
  input  logic             IM_stall,
  input  logic             DM_stall,
  input  logic             cnt_clear,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EXE_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] loaduse_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, FREEZE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, state_nxt;
  logic   freeze, load_use, do_flush, flush_pend;
  logic   sel_flush, sel_lu;

  assign freeze   = IM_stall | DM_stall;
  assign load_use = EXE_memRead && (EXE_rd_addr != 5'd0) &&
                    ((ID_rs1_used && (ID_rs1_addr == EXE_rd_addr)) ||
                     (ID_rs2_used && (ID_rs2_addr == EXE_rd_addr)));
  assign do_flush  = ~freeze & (EXE_branch_taken | flush_pend);
  assign sel_flush = do_flush;
  assign sel_lu    = ~freeze & ~do_flush & load_use;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (freeze)  state_nxt = FREEZE;
      FREEZE:  if (!freeze) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // A branch resolved while frozen must still squash IF/ID once the pipe moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   flush_pend <= 1'b0;
    else if (!freeze)          flush_pend <= 1'b0;
    else if (EXE_branch_taken) flush_pend <= 1'b1;
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EXE_flush = 1'b0;
    pipe_hold    = 1'b0;
    if (rst || freeze) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      pipe_hold    = 1'b1;
    end else if (do_flush) begin
      IF_ID_flush  = 1'b1;
      ID_EXE_flush = 1'b1;
    end else if (load_use) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EXE_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_cnt  <= '0;
      loaduse_cnt <= '0;
      flush_cnt   <= '0;
    end else if (cnt_clear) begin
      freeze_cnt  <= '0;
      loaduse_cnt <= '0;
      flush_cnt   <= '0;
    end else begin
      if (freeze && (freeze_cnt != '1))  freeze_cnt  <= freeze_cnt + ONE;
      if (sel_lu && (loaduse_cnt != '1)) loaduse_cnt <= loaduse_cnt + ONE;
      if (sel_flush && (flush_cnt != '1)) flush_cnt  <= flush_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations are queued as stimulus is
// applied and popped when the DUT outputs are sampled.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] LU   = 5'b00010;
  localparam logic [4:0] FL   = 5'b11110;
  localparam logic [4:0] FZ   = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs1_addr, ID_rs2_addr, EXE_rd_addr;
  logic ID_rs1_used, ID_rs2_used, EXE_memRead, EXE_branch_taken;
  logic IM_stall, DM_stall, cnt_clear;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, pipe_hold;
  logic [CNT_W-1:0] freeze_cnt, loaduse_cnt, flush_cnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EXE_memRead(EXE_memRead), .EXE_rd_addr(EXE_rd_addr),
    .EXE_branch_taken(EXE_branch_taken),
    .IM_stall(IM_stall), .DM_stall(DM_stall), .cnt_clear(cnt_clear),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EXE_flush(ID_EXE_flush), .pipe_hold(pipe_hold),
    .freeze_cnt(freeze_cnt), .loaduse_cnt(loaduse_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=%0h exp=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] ctl();
    return {27'd0, PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, pipe_hold};
  endfunction

  task automatic chk_ctl(input string tag, input logic [4:0] ectl);
    push({tag, "_ctl"}, {27'd0, ectl});
    pop_chk(ctl());
  endtask

  task automatic chk_cnt(input string tag, input int efz, input int elu, input int efl);
    push({tag, "_freeze_cnt"},  efz);
    push({tag, "_loaduse_cnt"}, elu);
    push({tag, "_flush_cnt"},   efl);
    pop_chk({28'd0, freeze_cnt});
    pop_chk({28'd0, loaduse_cnt});
    pop_chk({28'd0, flush_cnt});
  endtask

  // Called at posedge+1 with inputs already applied; checks control mid-cycle
  // and counters just after the next rising edge.
  task automatic cyc(input string tag, input logic [4:0] ectl,
                     input int efz, input int elu, input int efl);
    #2;
    chk_ctl(tag, ectl);
    @(posedge clk);
    #1;
    chk_cnt(tag, efz, elu, efl);
  endtask

  task automatic idle_inputs();
    ID_rs1_addr = 5'd0; ID_rs2_addr = 5'd0; EXE_rd_addr = 5'd0;
    ID_rs1_used = 1'b0; ID_rs2_used = 1'b0; EXE_memRead = 1'b0;
    EXE_branch_taken = 1'b0; IM_stall = 1'b0; DM_stall = 1'b0; cnt_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    chk_ctl("reset", FZ);
    chk_cnt("reset", 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    cyc("idle", NORM, 0, 0, 0);

    EXE_memRead = 1'b1; EXE_rd_addr = 5'd5; ID_rs1_addr = 5'd5; ID_rs1_used = 1'b1;
    cyc("loaduse_rs1", LU, 0, 1, 0);
    EXE_memRead = 1'b0;
    cyc("after_loaduse", NORM, 0, 1, 0);

    EXE_memRead = 1'b1; EXE_rd_addr = 5'd0; ID_rs1_addr = 5'd0; ID_rs1_used = 1'b1;
    cyc("x0_no_stall", NORM, 0, 1, 0);

    EXE_rd_addr = 5'd7; ID_rs1_addr = 5'd1; ID_rs2_addr = 5'd7; ID_rs2_used = 1'b0;
    cyc("rs2_unused", NORM, 0, 1, 0);
    ID_rs2_used = 1'b1;
    cyc("loaduse_rs2", LU, 0, 2, 0);

    idle_inputs();
    cnt_clear = 1'b1;
    cyc("clear1", NORM, 0, 0, 0);
    cnt_clear = 1'b0;
    EXE_memRead = 1'b1; EXE_rd_addr = 5'd5; ID_rs1_addr = 5'd5; ID_rs1_used = 1'b1;
    EXE_branch_taken = 1'b1;
    cyc("branch_beats_lu", FL, 0, 0, 1);

    idle_inputs();
    cnt_clear = 1'b1;
    cyc("clear2", NORM, 0, 0, 0);
    cnt_clear = 1'b0;
    DM_stall = 1'b1; EXE_branch_taken = 1'b1;
    cyc("frz_branch1", FZ, 1, 0, 0);
    EXE_branch_taken = 1'b0;
    cyc("frz_branch2", FZ, 2, 0, 0);
    cyc("frz_branch3", FZ, 3, 0, 0);
    DM_stall = 1'b0;
    cyc("pend_flush", FL, 3, 0, 1);
    cyc("pend_cleared", NORM, 3, 0, 1);

    cnt_clear = 1'b1;
    cyc("clear3", NORM, 0, 0, 0);
    cnt_clear = 1'b0;
    IM_stall = 1'b1;
    for (int i = 1; i <= 20; i++)
      cyc("sat", FZ, (i > 15) ? 15 : i, 0, 0);
    cnt_clear = 1'b1;
    cyc("clear_vs_inc", FZ, 0, 0, 0);
    cnt_clear = 1'b0;
    cyc("inc_after_clear", FZ, 1, 0, 0);
    EXE_branch_taken = 1'b1;
    cyc("frz_set_pend", FZ, 2, 0, 0);

    // Without the async reset this would be a pending flush cycle.
    rst = 1'b1; IM_stall = 1'b0; EXE_branch_taken = 1'b0;
    #1;
    chk_ctl("async_rst", FZ);
    chk_cnt("async_rst", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst", NORM, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
